// File: rtl/parity_chk_pkg.sv
// Shared definitions for the parity equivalence checker.
//   state_t     : run-control FSM states
//   MAX_LATENCY : deepest DUT latency the alignment line and drain counter support
//   lfsr_taps() : Galois (right-shift) tap masks giving a maximal-length sequence
//                 for widths 3..32
package parity_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int MAX_LATENCY = 15;

  // Tap masks for a right-shifting Galois LFSR. When the bit shifted out is 1,
  // the mask is XORed into the shifted state. Unsupported widths fall back to
  // the 3-bit mask so the function always returns something usable.
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] taps;
    case (w)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0006;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Galois LFSR stimulus source.
//   clk, rst_n : clock, asynchronous active-low reset (state returns to SEED)
//   load       : reload SEED (wins over step)
//   step       : advance one position
//   q          : current LFSR state
// A zero SEED would lock the register up, so it is replaced by 1.
module lfsr_gen
  import parity_chk_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [31:0]      TAPS32   = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS32[WIDTH-1:0];

  logic [WIDTH-1:0] state_q, state_d;

  // Next-state: reload, hold, or one Galois shift with the taps folded in
  // whenever a 1 falls off the low end.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED_EFF;
    end else if (step) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
    end
  end

  // State register; reset puts the generator back at the start of its sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/parity_equiv_checker.sv
// Self-checking equivalence harness for two single-bit-output implementations.
// Issues NUM_VECTORS stimulus vectors (all-zero first, then the LFSR sequence),
// compares f_a against f_b DUT_LATENCY cycles after each vector, and reports.
//   clk, rst_n     : clock, asynchronous active-low reset (aborts a run)
//   start          : begin a run; accepted only in IDLE or DONE
//   f_a, f_b       : outputs of the two implementations under comparison
//   D              : registered stimulus vector driven to both implementations
//   busy           : run in progress (RUN or DRAIN)
//   done, pass     : run finished / finished with no mismatches
//   mismatch       : one-cycle pulse per compared mismatch
//   err_count      : mismatches this run (saturating)
//   vec_count      : vectors issued this run (saturating at the counter width)
//   first_fail_idx : index of the first mismatching vector
//   first_fail_d   : stimulus value of the first mismatching vector
module parity_equiv_checker
  import parity_chk_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int NUM_VECTORS = 10,
  parameter int DUT_LATENCY = 0,
  parameter int SEED        = 1,
  parameter int CNT_W       = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f_a,
  input  logic             f_b,
  output logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_d
);

  // The internal vector counter must reach NUM_VECTORS even when the reported
  // counters are narrower; reported values saturate instead of wrapping.
  localparam int VEC_W = $clog2(NUM_VECTORS + 1);
  localparam int IDX_W = (VEC_W > CNT_W) ? VEC_W : CNT_W;
  localparam int DRN_W = $clog2(MAX_LATENCY + 1);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [31:0]      SEED32     = SEED;
  localparam logic [DRN_W-1:0] DRAIN_LAST = (DUT_LATENCY == 0) ? '0 : DRN_W'(DUT_LATENCY - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [IDX_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [WIDTH-1:0] ff_d_q, ff_d_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mis_q, mis_d;

  logic             lfsr_load, lfsr_step;
  logic [WIDTH-1:0] lfsr_q;

  // Slot entering the alignment line: a vector is on D exactly in RUN cycles.
  logic             s_valid;
  logic [IDX_W-1:0] s_idx;
  logic             al_valid;
  logic [IDX_W-1:0] al_idx;
  logic [CNT_W-1:0] al_idx_sat;
  logic [WIDTH-1:0] al_d;
  logic             cmp_fail;

  assign s_valid = (state_q == RUN);
  assign s_idx   = vec_q - IDX_W'(1);

  lfsr_gen #(
    .WIDTH (WIDTH),
    .SEED  (SEED32[WIDTH-1:0])
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  generate
    if (DUT_LATENCY == 0) begin : g_noline
      assign al_valid = s_valid;
      assign al_idx   = s_idx;
      assign al_d     = d_q;
    end else begin : g_line
      logic [DUT_LATENCY-1:0] vld_q, vld_d;
      logic [IDX_W-1:0]       idx_q [DUT_LATENCY];
      logic [IDX_W-1:0]       idx_d [DUT_LATENCY];
      logic [WIDTH-1:0]       dv_q  [DUT_LATENCY];
      logic [WIDTH-1:0]       dv_d  [DUT_LATENCY];

      // Shift the current slot one stage deeper each cycle so the tail lines up
      // with the DUT outputs that belong to it.
      always_comb begin
        vld_d[0] = s_valid;
        idx_d[0] = s_idx;
        dv_d[0]  = d_q;
        for (int i = 1; i < DUT_LATENCY; i++) begin
          vld_d[i] = vld_q[i-1];
          idx_d[i] = idx_q[i-1];
          dv_d[i]  = dv_q[i-1];
        end
      end

      // Line storage; cleared on reset so an aborted run leaves no stale slots.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          idx_q <= '{default: '0};
          dv_q  <= '{default: '0};
        end else begin
          vld_q <= vld_d;
          idx_q <= idx_d;
          dv_q  <= dv_d;
        end
      end

      assign al_valid = vld_q[DUT_LATENCY-1];
      assign al_idx   = idx_q[DUT_LATENCY-1];
      assign al_d     = dv_q[DUT_LATENCY-1];
    end

    if (IDX_W > CNT_W) begin : g_sat
      assign vec_count  = (|vec_q[IDX_W-1:CNT_W])  ? CNT_MAX : vec_q[CNT_W-1:0];
      assign al_idx_sat = (|al_idx[IDX_W-1:CNT_W]) ? CNT_MAX : al_idx[CNT_W-1:0];
    end else begin : g_nosat
      assign vec_count  = vec_q[CNT_W-1:0];
      assign al_idx_sat = al_idx[CNT_W-1:0];
    end
  endgenerate

  // Case inequality so an X/Z from either implementation is flagged in simulation.
  assign cmp_fail = al_valid && (f_a !== f_b);

  // Compare bookkeeping first, then the FSM. The start branch clears counters;
  // it can only fire in IDLE/DONE where the line is empty, so nothing is lost.
  // pass is taken from err_d so a failure on the last drained vector counts.
  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    vec_d     = vec_q;
    err_d     = err_q;
    ff_idx_d  = ff_idx_q;
    ff_d_d    = ff_d_q;
    drain_d   = drain_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    mis_d     = cmp_fail;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    if (cmp_fail) begin
      if (err_q == '0) begin
        ff_idx_d = al_idx_sat;
        ff_d_d   = al_d;
      end
      if (err_q != CNT_MAX) begin
        err_d = err_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          d_d       = '0;
          vec_d     = IDX_W'(1);
          err_d     = '0;
          ff_idx_d  = '0;
          ff_d_d    = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          lfsr_load = 1'b1;
        end
      end
      RUN: begin
        if (vec_q == IDX_W'(NUM_VECTORS)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          d_d       = lfsr_q;
          vec_d     = vec_q + IDX_W'(1);
          lfsr_step = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All control and reporting state; reset returns every output to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      d_q      <= '0;
      vec_q    <= '0;
      err_q    <= '0;
      ff_idx_q <= '0;
      ff_d_q   <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      ff_idx_q <= ff_idx_d;
      ff_d_q   <= ff_d_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      mis_q    <= mis_d;
    end
  end

  assign D              = d_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch       = mis_q;
  assign err_count      = err_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_d   = ff_d_q;

endmodule

// File: tb/tb_parity_equiv_checker.sv
// Testbench for parity_equiv_checker. Three instances share clock and reset:
//   u_main : WIDTH=7, N=10, LAT=0; its f_a/f_b are steered by mode_m
//   u_lat  : LAT=2, both implementations register parity twice
//   u_sat  : CNT_W=3, f_b permanently inverted
module tb_parity_equiv_checker;

  typedef struct {
    int         idx;
    logic [6:0] d;
  } vec_t;

  vec_t tbl [10];

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start_m = 1'b0, start_l = 1'b0, start_s = 1'b0;

  logic [6:0] d_m, ffd_m, d_l, ffd_l, d_s, ffd_s;
  logic       busy_m, done_m, pass_m, mis_m;
  logic       busy_l, done_l, pass_l, mis_l;
  logic       busy_s, done_s, pass_s, mis_s;
  logic [3:0] err_m, vec_m, ffi_m, err_l, vec_l, ffi_l;
  logic [2:0] err_s, vec_s, ffi_s;

  logic [1:0] mode_m = 2'd0;
  logic       p1_m = 1'b0, p2_m = 1'b0, p1_l = 1'b0, p2_l = 1'b0;
  logic       par_m, fa_m, fb_m, fa_s, fb_s;

  int sel = 0;
  logic        cur_busy, cur_done, cur_mis, cur_pass;
  logic [31:0] cur_err, cur_vec, cur_ffi, cur_ffd, cur_d;

  logic [6:0] cap_d [16];
  int busy_cycles, pulses, cap_n;
  logic [31:0] snap_err, snap_vec, snap_d;
  logic        snap_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Two-stage registered parity, standing in for implementations with latency 2.
  always @(posedge clk) begin
    p1_m <= ^d_m;
    p2_m <= p1_m;
    p1_l <= ^d_l;
    p2_l <= p1_l;
  end

  // mode 0: equal; 1: B flipped only while vector 3 (7'h30) is on D;
  // 2: B always inverted; 3: A has latency 2 while B is combinational.
  assign par_m = ^d_m;
  assign fa_m  = (mode_m == 2'd3) ? p2_m : par_m;
  assign fb_m  = (mode_m == 2'd1) ? (par_m ^ (d_m == 7'h30)) :
                 (mode_m == 2'd2) ? ~par_m : par_m;
  assign fa_s  = ^d_s;
  assign fb_s  = ~fa_s;

  assign cur_busy = (sel == 0) ? busy_m : (sel == 1) ? busy_l : busy_s;
  assign cur_done = (sel == 0) ? done_m : (sel == 1) ? done_l : done_s;
  assign cur_pass = (sel == 0) ? pass_m : (sel == 1) ? pass_l : pass_s;
  assign cur_mis  = (sel == 0) ? mis_m  : (sel == 1) ? mis_l  : mis_s;
  assign cur_err  = (sel == 0) ? 32'(err_m) : (sel == 1) ? 32'(err_l) : 32'(err_s);
  assign cur_vec  = (sel == 0) ? 32'(vec_m) : (sel == 1) ? 32'(vec_l) : 32'(vec_s);
  assign cur_ffi  = (sel == 0) ? 32'(ffi_m) : (sel == 1) ? 32'(ffi_l) : 32'(ffi_s);
  assign cur_ffd  = (sel == 0) ? 32'(ffd_m) : (sel == 1) ? 32'(ffd_l) : 32'(ffd_s);
  assign cur_d    = (sel == 0) ? 32'(d_m)   : (sel == 1) ? 32'(d_l)   : 32'(d_s);

  parity_equiv_checker #(.WIDTH(7), .NUM_VECTORS(10), .DUT_LATENCY(0), .SEED(1)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start_m), .f_a(fa_m), .f_b(fb_m),
    .D(d_m), .busy(busy_m), .done(done_m), .pass(pass_m), .mismatch(mis_m),
    .err_count(err_m), .vec_count(vec_m), .first_fail_idx(ffi_m), .first_fail_d(ffd_m)
  );

  parity_equiv_checker #(.WIDTH(7), .NUM_VECTORS(10), .DUT_LATENCY(2), .SEED(1)) u_lat (
    .clk(clk), .rst_n(rst_n), .start(start_l), .f_a(p2_l), .f_b(p2_l),
    .D(d_l), .busy(busy_l), .done(done_l), .pass(pass_l), .mismatch(mis_l),
    .err_count(err_l), .vec_count(vec_l), .first_fail_idx(ffi_l), .first_fail_d(ffd_l)
  );

  parity_equiv_checker #(.WIDTH(7), .NUM_VECTORS(10), .DUT_LATENCY(0), .SEED(1), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .f_a(fa_s), .f_b(fb_s),
    .D(d_s), .busy(busy_s), .done(done_s), .pass(pass_s), .mismatch(mis_s),
    .err_count(err_s), .vec_count(vec_s), .first_fail_idx(ffi_s), .first_fail_d(ffd_s)
  );

  // Single comparison point: counts every check and reports any difference.
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_m = v;
    else if (which == 1) start_l = v;
    else start_s = v;
  endtask

  // Called on a falling edge: pulse start on one instance, then watch it until
  // done (bounded), counting busy cycles and mismatch pulses and capturing D.
  // extra_at >= 0 raises start again that many cycles into the run.
  task automatic apply_stimulus(input int which, input int extra_at);
    sel = which;
    busy_cycles = 0;
    pulses = 0;
    cap_n = 0;
    set_start(which, 1'b1);
    @(negedge clk);
    snap_err  = cur_err;
    snap_vec  = cur_vec;
    snap_d    = cur_d;
    snap_done = cur_done;
    for (int c = 0; c < 60; c++) begin
      set_start(which, 1'b0);
      if (cur_mis) pulses++;
      if (cur_done) break;
      if (cur_busy) begin
        if (cap_n < 16) cap_d[cap_n] = cur_d[6:0];
        cap_n++;
        busy_cycles++;
      end
      if (c == extra_at) set_start(which, 1'b1);
      @(negedge clk);
    end
    check_output("run_reaches_done", 32'(cur_done), 32'd1);
  endtask

  // The issued vectors must match the hand-computed sequence table.
  task automatic check_seq(input string tag);
    for (int i = 0; i < 10; i++) begin
      check_output($sformatf("%s_vec%0d", tag, tbl[i].idx), 32'(cap_d[i]), 32'(tbl[i].d));
    end
  endtask

  initial begin
    // Vector 0 is zero; later ones walk the x^7+x^6+1 Galois LFSR from seed 1.
    tbl[0] = '{0, 7'h00}; tbl[1] = '{1, 7'h01}; tbl[2] = '{2, 7'h60};
    tbl[3] = '{3, 7'h30}; tbl[4] = '{4, 7'h18}; tbl[5] = '{5, 7'h0C};
    tbl[6] = '{6, 7'h06}; tbl[7] = '{7, 7'h03}; tbl[8] = '{8, 7'h61};
    tbl[9] = '{9, 7'h50};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check_output("rst_D", 32'(d_m), 32'd0);
    check_output("rst_busy", 32'(busy_m), 32'd0);
    check_output("rst_done", 32'(done_m), 32'd0);
    check_output("rst_pass", 32'(pass_m), 32'd0);
    check_output("rst_err", 32'(err_m), 32'd0);
    check_output("rst_vec", 32'(vec_m), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Equal implementations, no latency
    mode_m = 2'd0;
    apply_stimulus(0, -1);
    check_output("t1_first_D", snap_d, 32'd0);
    check_output("t1_busy_cycles", 32'(busy_cycles), 32'd11);
    check_output("t1_pass", 32'(cur_pass), 32'd1);
    check_output("t1_err", cur_err, 32'd0);
    check_output("t1_vec", cur_vec, 32'd10);
    check_output("t1_pulses", 32'(pulses), 32'd0);
    check_output("t1_ffi", cur_ffi, 32'd0);
    check_output("t1_ffd", cur_ffd, 32'd0);
    check_output("t1_D_held_drain", 32'(cap_d[10]), 32'h50);
    check_seq("t1");

    // Single failure on vector 3
    mode_m = 2'd1;
    apply_stimulus(0, -1);
    check_output("t2_pulses", 32'(pulses), 32'd1);
    check_output("t2_err", cur_err, 32'd1);
    check_output("t2_ffi", cur_ffi, 32'd3);
    check_output("t2_ffd", cur_ffd, 32'h30);
    check_output("t2_pass", 32'(cur_pass), 32'd0);

    // Restart from DONE clears the previous run's results
    mode_m = 2'd0;
    apply_stimulus(0, -1);
    check_output("t6_restart_err", snap_err, 32'd0);
    check_output("t6_restart_vec", snap_vec, 32'd1);
    check_output("t6_restart_done", 32'(snap_done), 32'd0);
    check_output("t6_restart_pass", 32'(cur_pass), 32'd1);
    check_seq("t6_restart");

    // start during RUN is ignored
    apply_stimulus(0, 3);
    check_output("t6_busy_cycles", 32'(busy_cycles), 32'd11);
    check_output("t6_vec", cur_vec, 32'd10);
    check_seq("t6_midstart");

    // Every vector fails
    mode_m = 2'd2;
    apply_stimulus(0, -1);
    check_output("t4_err", cur_err, 32'd10);
    check_output("t4_pulses", 32'(pulses), 32'd10);
    check_output("t4_ffi", cur_ffi, 32'd0);
    check_output("t4_ffd", cur_ffd, 32'd0);
    check_output("t4_pass", 32'(cur_pass), 32'd0);

    // Latency 2, aligned
    apply_stimulus(1, -1);
    check_output("t3_busy_cycles", 32'(busy_cycles), 32'd12);
    check_output("t3_pass", 32'(cur_pass), 32'd1);
    check_output("t3_err", cur_err, 32'd0);
    check_output("t3_vec", cur_vec, 32'd10);
    check_seq("t3");

    // Latency-2 implementation against a LAT=0 checker: vectors 1, 3, 8 differ
    mode_m = 2'd3;
    apply_stimulus(0, -1);
    check_output("t3_misalign_err", cur_err, 32'd3);
    check_output("t3_misalign_ffi", cur_ffi, 32'd1);
    check_output("t3_misalign_ffd", cur_ffd, 32'h01);
    check_output("t3_misalign_pass", 32'(cur_pass), 32'd0);

    // Saturating 3-bit error counter
    apply_stimulus(2, -1);
    check_output("t4_sat_err", cur_err, 32'd7);
    check_output("t4_sat_ffi", cur_ffi, 32'd0);
    check_output("t4_sat_ffd", cur_ffd, 32'd0);
    check_output("t4_sat_pass", 32'(cur_pass), 32'd0);

    // Asynchronous reset mid-run, then a clean rerun
    mode_m = 2'd0;
    sel = 0;
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (vec_m == 4'd5) break;
      @(negedge clk);
    end
    check_output("t5_reached_vec5", 32'(vec_m), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check_output("t5_D", 32'(d_m), 32'd0);
    check_output("t5_busy", 32'(busy_m), 32'd0);
    check_output("t5_done", 32'(done_m), 32'd0);
    check_output("t5_err", 32'(err_m), 32'd0);
    check_output("t5_vec", 32'(vec_m), 32'd0);
    check_output("t5_mis", 32'(mis_m), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(0, -1);
    check_output("t5_rerun_pass", 32'(cur_pass), 32'd1);
    check_seq("t5_rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
